// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : PC holder and req/ack instruction fetcher for a single-cycle
//                MIPS datapath; forms the next PC from Jump/PCSrc/SignImm.
//                Optional macro FETCH_PERF_EN adds retired/stall/wait counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] SignImm,
    input  logic        Stall,
    input  logic        Halt,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_RData,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
`ifdef FETCH_PERF_EN
    output logic [31:0] Retired_Count,
    output logic [31:0] Stall_Cycles,
    output logic [31:0] Wait_Cycles,
`endif
    output logic        Halted
);

    localparam logic [1:0]  S_FETCH    = 2'd0;
    localparam logic [1:0]  S_EXEC     = 2'd1;
    localparam logic [1:0]  S_HALTED   = 2'd2;
    localparam logic [31:0] c_addr_mask = 32'hFFFF_FFFC;
    localparam logic [31:0] c_reset_pc  = RESET_PC & c_addr_mask;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;
    logic        w_fetch_done;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_off = SignImm << 2;
    // The ack only counts while our own request is visibly asserted.
    assign w_fetch_done = (r_state == S_FETCH) && r_req && Imem_Ack;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (Jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (PCSrc) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; Stall outranks Halt in EXEC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_done) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!Stall) begin
                    w_state_nxt = Halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Output decode from state
    always_comb begin
        Instr_Valid = (r_state == S_EXEC);
        Halted      = (r_state == S_HALTED);
        Instr       = (r_state == S_EXEC) ? r_instr : NOP_INSTR;
    end

    // Request raises one edge after reset release, or on the EXEC->FETCH edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_pc    <= c_reset_pc;
            r_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (Imem_Ack) begin
                        r_instr <= Imem_RData;
                        r_req   <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (!Stall) begin
                        r_pc  <= w_next_pc & c_addr_mask;
                        r_req <= !Halt;
                    end
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

    assign Imem_Req  = r_req;
    assign Imem_Addr = r_pc;
    assign PC        = r_pc;
    assign PCPlus4   = w_pc_plus4;

`ifdef FETCH_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_stall_cyc;
    logic [31:0] r_wait_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired   <= 32'd0;
            r_stall_cyc <= 32'd0;
            r_wait_cyc  <= 32'd0;
        end else begin
            case (r_state)
                S_EXEC: begin
                    if (Stall) begin
                        r_stall_cyc <= r_stall_cyc + 32'd1;
                    end else begin
                        r_retired <= r_retired + 32'd1;
                    end
                end
                S_FETCH: begin
                    if (!Imem_Ack) begin
                        r_wait_cyc <= r_wait_cyc + 32'd1;
                    end
                end
                default: begin
                    r_retired <= r_retired;
                end
            endcase
        end
    end

    assign Retired_Count = r_retired;
    assign Stall_Cycles  = r_stall_cyc;
    assign Wait_Cycles   = r_wait_cyc;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side producer for the single-cycle MIPS datapath.
- Holds the PC and fetches words from instruction memory over a req/ack handshake.
- Presents Instr to the control unit, then consumes the control unit's PCSrc/Jump plus the datapath's SignImm to form the next PC.
- Sits between instruction memory and the control/decoder logic, closing the next-PC loop.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.
- NOP_INSTR, 32'h0000_0000, value driven on Instr whenever no valid instruction is held.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCSrc  input  1  branch taken (Branch & zero) from the control unit; sampled in EXEC only.
- Jump  input  1  jump from the control unit; sampled in EXEC only.
- SignImm  input  32  sign-extended branch offset, in words.
- Stall  input  1  holds the current instruction in EXEC.
- Halt  input  1  stops fetching after the current instruction.
- Imem_Req  output  1  fetch request.
- Imem_Addr  output  32  fetch address; equals PC.
- Imem_Ack  input  1  read data valid; sampled only while Imem_Req=1.
- Imem_RData  input  32  instruction word.
- Instr  output  32  instruction to the decoder.
- Instr_Valid  output  1  Instr is valid and executing this cycle.
- PC  output  32  current PC.
- PCPlus4  output  32  PC+4, combinational.
- Halted  output  1  block is in the HALTED state.

Behaviour:
- Reset (asynchronous, active-high):
  - PC=RESET_PC & ~3, Instr=NOP_INSTR.
  - Instr_Valid=0, Imem_Req=0, Halted=0.
  - State goes to FETCH. The first Imem_Req rises on the first clock edge after rst deasserts.
- States: FETCH, EXEC, HALTED (2-bit encoding).
- FETCH:
  - Imem_Req=1 and Imem_Addr=PC, both held stable until ack.
  - On a rising edge with Imem_Ack=1: Instr<=Imem_RData, Imem_Req<=0, go to EXEC.
  - Minimum latency from request to EXEC is 1 cycle (ack in the first request cycle). Unbounded wait is allowed.
- EXEC:
  - Instr_Valid=1 and Instr is held.
  - Stall=1: remain in EXEC. PC and Instr are unchanged and PCSrc/Jump are ignored.
  - Stall=0 and Halt=0: PC<=next_pc, go to FETCH.
  - Stall=0 and Halt=1: PC<=next_pc, go to HALTED.
  - Stall has priority over Halt.
- next_pc priority:
  - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - else PCSrc=1: PCPlus4 + {SignImm[29:0], 2'b00}.
  - else: PCPlus4.
  - All adds are modulo 2^32. PC 32'hFFFF_FFFC plus 4 wraps to 0.
  - Jump and PCSrc together: Jump wins.
- HALTED:
  - Halted=1, Imem_Req=0, Instr_Valid=0, Instr=NOP_INSTR, PC frozen.
  - Exit only through rst.
- Instr outside EXEC:
  - Instr_Valid=0 in FETCH and HALTED.
  - Instr shows NOP_INSTR whenever Instr_Valid=0, so the decoder never sees stale words.
- Imem_Ack outside FETCH is ignored.
- Reset during FETCH aborts the request; a late ack after reset is ignored unless Imem_Req=1.
- PC low bits [1:0] are always 0.
- All outputs except PCPlus4 are registered or decoded from state only. There is no combinational path from Imem_Ack to Imem_Req.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, the block adds these outputs:
  - Retired_Count, 32 bits: increments on each EXEC exit with Stall=0.
  - Stall_Cycles, 32 bits: increments on each EXEC cycle with Stall=1.
  - Wait_Cycles, 32 bits: increments on each FETCH cycle with Imem_Ack=0.
- Counter behaviour: all three reset to 0, wrap modulo 2^32, and freeze in HALTED.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset release, ack in the first request cycle, RData=32'h2008_0005, no branch -> Imem_Addr=0, Instr_Valid pulses 1 cycle with Instr=32'h2008_0005, next Imem_Addr=4.
- Ack delayed 3 cycles -> Imem_Req/Imem_Addr stable for 4 cycles, Instr_Valid=0 and Instr=NOP_INSTR throughout, then EXEC.
- PC=0x100 in EXEC, PCSrc=1, SignImm=32'hFFFF_FFFE -> next PC=0x100+4-8=0xFC; with SignImm=3 -> 0x110.
- PC=0x1000_0040, Jump=1, PCSrc=1, Instr[25:0]=26'h0000_010 -> next PC=0x1000_0040 (Jump wins); then PC=0xFFFF_FFFC with no branch -> wraps to 0.
- Stall=1 for 2 EXEC cycles with Halt=1 and PCSrc=1 -> PC and Instr unchanged, stays in EXEC; Stall=0 -> HALTED, Halted=1, Imem_Req stays 0 for 10+ cycles.
- rst asserted mid-FETCH with ack arriving the next cycle -> PC=RESET_PC immediately and the ack is ignored; with FETCH_PERF_EN, 5 retired instructions give Retired_Count=5, and reset clears all counters.
